rkey_mem_arbiter: RTL and testbench
===================================

RKEY_MEM_ARBITER -- requirements
Module: rkey_mem_arbiter

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  in  1  begin new key load; single-cycle pulse.
REQ-004 SHALL have port: key_len  in  2  00=11 keys, 01=13 keys, 10/11=15 keys; sampled only when start=1.
REQ-005 SHALL have port: wr_req  in  1  key-expansion writer presents one round key.
REQ-006 SHALL have port: wr_data  in  128  round key to store.
REQ-007 SHALL have port: wr_gnt  out  1  write accepted this cycle (combinational).
REQ-008 SHALL have port: rd_req  in  1  cipher engine requests a round key.
REQ-009 SHALL have port: rd_idx  in  4  requested round-key index.
REQ-010 SHALL have port: rd_gnt  out  1  read accepted this cycle (combinational).
REQ-011 SHALL have port: rd_valid  out  1  rd_data valid; registered.
REQ-012 SHALL have port: rd_data  out  128  round key; direct pass-through of mem_rdata.
REQ-013 SHALL have port: rd_err  out  1  one-cycle pulse for a rejected out-of-range read; registered.
REQ-014 SHALL have port: keys_ready  out  1  all keys for the latched key_len are stored; registered.
REQ-015 SHALL have ports: mem_addr  out  4; mem_we  out  1; mem_wdata  out  128; mem_rdata  in  128.
- These connect to the 15x128 round-key store.
- The store's read data is registered: data appears 1 cycle after the address is sampled.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, READY, latch last = key count - 1 (10/12/14) on start, and maintain a 4-bit write pointer wptr.
REQ-017 start in any state SHALL:
- enter LOAD next cycle;
- set wptr=0 and keys_ready=0;
- cause wr_gnt=0 and rd_gnt=0 in that same cycle.
REQ-018 In LOAD, wr_req=1 SHALL give wr_gnt=1, mem_we=1, mem_addr=wptr, mem_wdata=wr_data in that cycle, and increment wptr at the edge.
REQ-019 A granted write with wptr==last SHALL:
- move the FSM to READY;
- set keys_ready=1 the next cycle;
- leave wptr at last (no wrap).
REQ-020 wr_req in IDLE or READY SHALL give wr_gnt=0, mem_we=0, and no state change; the write is ignored.
REQ-021 rd_req in IDLE or LOAD SHALL give rd_gnt=0 with no memory access; the requester holds rd_req (write has priority during load).
REQ-022 In READY, rd_req=1 with rd_idx<=last SHALL give rd_gnt=1 and mem_addr=rd_idx, mem_we=0, then rd_valid=1 exactly one cycle later.
REQ-023 In READY, rd_req=1 with rd_idx>last SHALL give rd_gnt=0, no access, and rd_err=1 the next cycle for one cycle.
REQ-024 Back-to-back granted reads SHALL be supported at 1 per cycle, with rd_valid continuously high.
REQ-025 When no access is granted, mem_addr SHALL be 0, mem_we 0, and mem_wdata 0.
REQ-026 A read granted in the cycle before start SHALL still produce rd_valid the following cycle, even though keys_ready drops.
REQ-027 mem_we SHALL never be 1 while rd_gnt=1; at most one memory access per cycle.

Reset
REQ-028 While rst_n=0:
- FSM=IDLE, wptr=0, last=14;
- keys_ready=0, rd_valid=0, rd_err=0;
- wr_gnt, rd_gnt and mem_we forced to 0.
REQ-029 Reset asserted mid-LOAD SHALL abandon the load; after release, a new start is required before any grant.

Verification
REQ-030 Reset, start with key_len=00, then 11 consecutive wr_req with data 0..10 -> expect:
- wr_gnt on all 11;
- mem_addr 0..10;
- keys_ready=1 one cycle after the 11th write;
- a 12th wr_req gets wr_gnt=0.
REQ-031 After REQ-030, rd_idx 3,4,5 on consecutive cycles -> rd_gnt=1 each cycle, rd_valid high 3 cycles, rd_data=3,4,5.
REQ-032 key_len=00 loaded, rd_idx=12 -> rd_gnt=0, mem_we=0, rd_err pulse 1 cycle later, rd_valid=0.
REQ-033 key_len=10 load with rd_req held from LOAD entry -> rd_gnt=0 throughout 15 writes; first rd_gnt in the cycle keys_ready rises; reading index 14 returns the 15th key.
REQ-034 start and wr_req in the same cycle while in LOAD at wptr=5 -> wr_gnt=0, and the next granted write goes to mem_addr 0.
REQ-035 rst_n asserted after 7 writes -> keys_ready=0; post-reset rd_req and wr_req are not granted until start.

Source files
------------

// File: rtl/rkey_mem_arbiter_if.sv
// Client-side bus of the round-key store arbiter.
// One key-expansion writer and one cipher-engine reader share this bundle,
// together with the key-load control (start/key_len) and status (keys_ready).
// The slave modport is the arbiter; the master modport is the client side.
interface rkey_mem_arbiter_if;
    logic         start;
    logic [1:0]   key_len;
    logic         wr_req;
    logic [127:0] wr_data;
    logic         wr_gnt;
    logic         rd_req;
    logic [3:0]   rd_idx;
    logic         rd_gnt;
    logic         rd_valid;
    logic [127:0] rd_data;
    logic         rd_err;
    logic         keys_ready;

    modport master (
        output start, key_len, wr_req, wr_data, rd_req, rd_idx,
        input  wr_gnt, rd_gnt, rd_valid, rd_data, rd_err, keys_ready
    );

    modport slave (
        input  start, key_len, wr_req, wr_data, rd_req, rd_idx,
        output wr_gnt, rd_gnt, rd_valid, rd_data, rd_err, keys_ready
    );
endinterface

// File: rtl/rkey_mem_arbiter.sv
// Arbiter for a 15x128 round-key store shared by the key-expansion writer
// and the cipher engine reader.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   bus (slave)    start/key_len load control, write and read handshakes,
//                  rd_valid/rd_data/rd_err read return, keys_ready status
//   mem_addr/we/wdata  one access per cycle toward the store
//   mem_rdata      store read data, registered inside the store (1 cycle)
//
// state  | meaning
// IDLE   | no key loaded since reset; all requests refused
// LOAD   | accepting writes at wptr until wptr reaches last
// READY  | all keys stored; in-range reads granted, out-of-range flagged
module rkey_mem_arbiter (
    input  logic                 clk,
    input  logic                 rst_n,
    rkey_mem_arbiter_if.slave    bus,
    output logic [3:0]           mem_addr,
    output logic                 mem_we,
    output logic [127:0]         mem_wdata,
    input  logic [127:0]         mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] wptr;
    logic [3:0] last;
    logic       keys_ready_q;
    logic       rd_valid_q;
    logic       rd_err_q;

    logic       wr_gnt;
    logic       rd_gnt;
    logic       rd_oob;

    // start pre-empts every grant in its own cycle so a new load never
    // overlaps an access belonging to the previous key schedule.
    assign wr_gnt = (state == LOAD)  && bus.wr_req && !bus.start;
    assign rd_gnt = (state == READY) && bus.rd_req && !bus.start
                    && (bus.rd_idx <= last);
    assign rd_oob = (state == READY) && bus.rd_req && !bus.start
                    && (bus.rd_idx > last);

    // wr_gnt and rd_gnt are mutually exclusive by state, so the store sees
    // at most one access per cycle and an idle bus is all zeros.
    always_comb begin
        mem_addr  = 4'd0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (wr_gnt) begin
            mem_addr  = wptr;
            mem_we    = 1'b1;
            mem_wdata = bus.wr_data;
        end else if (rd_gnt) begin
            mem_addr  = bus.rd_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wptr         <= 4'd0;
            last         <= 4'd14;
            keys_ready_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            // A read granted just before start still returns its data.
            rd_valid_q <= rd_gnt;
            rd_err_q   <= rd_oob;
            if (bus.start) begin
                state        <= LOAD;
                wptr         <= 4'd0;
                keys_ready_q <= 1'b0;
                case (bus.key_len)
                    2'b00:   last <= 4'd10;
                    2'b01:   last <= 4'd12;
                    default: last <= 4'd14;
                endcase
            end else begin
                case (state)
                    LOAD: begin
                        if (wr_gnt) begin
                            // Pointer parks on last so it never wraps.
                            if (wptr == last) begin
                                state        <= READY;
                                keys_ready_q <= 1'b1;
                            end else begin
                                wptr <= wptr + 4'd1;
                            end
                        end
                    end
                    READY:   state <= READY;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.wr_gnt     = wr_gnt;
    assign bus.rd_gnt     = rd_gnt;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.keys_ready = keys_ready_q;
    assign bus.rd_data    = mem_rdata;

endmodule

// File: tb/tb_rkey_mem_arbiter.sv
module tb_rkey_mem_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   mem_addr;
    logic         mem_we;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;

    rkey_mem_arbiter_if bus ();

    rkey_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-key store model: synchronous write, registered read.
    logic [127:0] store [0:15];
    always @(posedge clk) begin
        if (mem_we) store[mem_addr] <= mem_wdata;
        mem_rdata <= store[mem_addr];
    end

    typedef struct {
        logic         st;
        logic [1:0]   kl;
        logic         wr;
        logic [7:0]   wd;
        logic         rr;
        logic [3:0]   ri;
        logic         e_wg;
        logic         e_rg;
        logic [3:0]   e_addr;
        logic         e_kr;
        logic         e_rv;
        logic         e_re;
        logic [7:0]   e_rd;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(int st, int kl, int wr, int wd, int rr, int ri,
                                int wg, int rg, int addr, int kr, int rv,
                                int re, int rd);
        vec_t v;
        v.st = 1'(st);   v.kl = 2'(kl);   v.wr = 1'(wr);   v.wd = 8'(wd);
        v.rr = 1'(rr);   v.ri = 4'(ri);   v.e_wg = 1'(wg); v.e_rg = 1'(rg);
        v.e_addr = 4'(addr); v.e_kr = 1'(kr); v.e_rv = 1'(rv);
        v.e_re = 1'(re); v.e_rd = 8'(rd);
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // mid-cycle, so registered outputs show the result of earlier edges.
    task automatic step(input vec_t v, input int row);
        logic [127:0] wdat;
        @(posedge clk);
        #1;
        wdat = {16{v.wd}};
        bus.start   = v.st;
        bus.key_len = v.kl;
        bus.wr_req  = v.wr;
        bus.wr_data = wdat;
        bus.rd_req  = v.rr;
        bus.rd_idx  = v.ri;
        #5;
        chk($sformatf("wr_gnt[%0d]", row),     128'(bus.wr_gnt),     128'(v.e_wg));
        chk($sformatf("rd_gnt[%0d]", row),     128'(bus.rd_gnt),     128'(v.e_rg));
        chk($sformatf("mem_we[%0d]", row),     128'(mem_we),         128'(v.e_wg));
        chk($sformatf("mem_addr[%0d]", row),   128'(mem_addr),       128'(v.e_addr));
        chk($sformatf("mem_wdata[%0d]", row),  mem_wdata,            v.e_wg ? wdat : 128'd0);
        chk($sformatf("keys_ready[%0d]", row), 128'(bus.keys_ready), 128'(v.e_kr));
        chk($sformatf("rd_valid[%0d]", row),   128'(bus.rd_valid),   128'(v.e_rv));
        chk($sformatf("rd_err[%0d]", row),     128'(bus.rd_err),     128'(v.e_re));
        if (v.e_rv)
            chk($sformatf("rd_data[%0d]", row), bus.rd_data, {16{v.e_rd}});
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.key_len = 2'b00;
        bus.wr_req  = 1'b0;
        bus.wr_data = '0;
        bus.rd_req  = 1'b0;
        bus.rd_idx  = 4'd0;

        // Reset state, requests present while reset is held.
        #3;
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        #10;
        chk("rst_wr_gnt",     128'(bus.wr_gnt),     128'd0);
        chk("rst_rd_gnt",     128'(bus.rd_gnt),     128'd0);
        chk("rst_mem_we",     128'(mem_we),         128'd0);
        chk("rst_keys_ready", 128'(bus.keys_ready), 128'd0);
        chk("rst_rd_valid",   128'(bus.rd_valid),   128'd0);
        chk("rst_rd_err",     128'(bus.rd_err),     128'd0);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        rst_n = 1'b1;

        // 11-key load, reads, out-of-range and boundary reads.
        tbl.push_back(mk(0,0,0,0,    0,0,  0,0,0,  0,0,0,0));
        tbl.push_back(mk(0,0,1,8'h99,1,0,  0,0,0,  0,0,0,0));
        tbl.push_back(mk(1,0,1,8'h98,0,0,  0,0,0,  0,0,0,0));
        for (int i = 0; i <= 10; i++)
            tbl.push_back(mk(0,0,1,i,0,0,  1,0,i,  0,0,0,0));
        tbl.push_back(mk(0,0,1,8'h77,0,0,  0,0,0,  1,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,3,      0,1,3,  1,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,4,      0,1,4,  1,1,0,3));
        tbl.push_back(mk(0,0,0,0,1,5,      0,1,5,  1,1,0,4));
        tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,  1,1,0,5));
        tbl.push_back(mk(0,0,0,0,1,12,     0,0,0,  1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,  1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,  1,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,10,     0,1,10, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,11,     0,0,0,  1,1,0,10));
        tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,  1,0,1,0));
        // Read granted right before start still returns data.
        tbl.push_back(mk(0,0,0,0,1,2,      0,1,2,  1,0,0,0));
        tbl.push_back(mk(1,2,0,0,1,0,      0,0,0,  1,1,0,2));
        // Partial 15-key load, restarted at wptr=5 with a colliding write.
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,1,8'h60+i,1,14, 1,0,i, 0,0,0,0));
        tbl.push_back(mk(1,2,1,8'hAA,1,14, 0,0,0,  0,0,0,0));
        // Full 15-key load with the reader holding rd_req throughout.
        for (int i = 0; i <= 14; i++)
            tbl.push_back(mk(0,0,1,8'h20+i,1,14, 1,0,i, 0,0,0,0));
        tbl.push_back(mk(0,0,0,0,1,14,     0,1,14, 1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,      0,0,0,  1,1,0,8'h2E));

        foreach (tbl[k]) step(tbl[k], k);

        // Reset mid-load after 7 writes of a 13-key load.
        step(mk(1,1,0,0,0,0, 0,0,0, 1,0,0,0), 100);
        for (int i = 0; i < 7; i++)
            step(mk(0,0,1,8'h40+i,0,0, 1,0,i, 0,0,0,0), 101 + i);
        @(posedge clk);
        #1;
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        bus.rd_idx = 4'd0;
        rst_n = 1'b0;
        #4;
        chk("midrst_wr_gnt",     128'(bus.wr_gnt),     128'd0);
        chk("midrst_mem_we",     128'(mem_we),         128'd0);
        chk("midrst_keys_ready", 128'(bus.keys_ready), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            step(mk(0,0,1,8'h33,1,0, 0,0,0, 0,0,0,0), 110 + i);

        // Fresh 13-key load; last index 12 readable, 13 rejected.
        step(mk(1,1,0,0,0,0, 0,0,0, 0,0,0,0), 120);
        for (int i = 0; i <= 12; i++)
            step(mk(0,0,1,8'h50+i,0,0, 1,0,i, 0,0,0,0), 121 + i);
        step(mk(0,0,0,0,1,12, 0,1,12, 1,0,0,0),    140);
        step(mk(0,0,0,0,1,13, 0,0,0,  1,1,0,8'h5C), 141);
        step(mk(0,0,0,0,0,0,  0,0,0,  1,0,1,0),     142);
        step(mk(0,0,0,0,0,0,  0,0,0,  1,0,0,0),     143);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
